// File: rtl/dvp_camera_tx_pkg.sv
// dvp_pkg: shared types and helpers for the DVP camera source.
//   dvp_state_e  - frame FSM states
//   rgb444_t     - {R,G,B} 4-bit-per-channel pixel
//   pack_hi/lo   - split a pixel into its two DVP bytes
//   bar_colour   - colour of one of the 8 vertical test bars
package dvp_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StVsync,
        StBack,
        StActive,
        StFront
    } dvp_state_e;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    // First byte on the wire: {4'h0, R}
    function automatic logic [7:0] pack_hi(input rgb444_t p);
        return {4'h0, p.r};
    endfunction

    // Second byte on the wire: {G, B}
    function automatic logic [7:0] pack_lo(input rgb444_t p);
        return {p.g, p.b};
    endfunction

    // Bar 0 is white, bar 7 is black; bit2/1/0 of (7-idx) select R/G/B.
    function automatic rgb444_t bar_colour(input logic [2:0] idx);
        logic [2:0] m;
        m = 3'd7 - idx;
        return '{r: {4{m[2]}}, g: {4{m[1]}}, b: {4{m[0]}}};
    endfunction

endpackage

// File: rtl/dvp_camera_tx_if.sv
// dvp_camera_tx_if: DVP sensor-side bus (vsync, href, p_data).
//   master - the camera source driving the bus
//   slave  - the capture block sampling the bus
interface dvp_camera_tx_if;
    logic       vsync;
    logic       href;
    logic [7:0] p_data;

    modport master (output vsync, output href, output p_data);
    modport slave  (input vsync, input href, input p_data);
endinterface

// File: rtl/dvp_camera_tx_timing_gen.sv
// dvp_timing_gen: frame FSM plus h/v counters for the DVP source.
// Ports:
//   p_clock, reset     - byte clock, synchronous active-high reset
//   enable             - start/continue frames (sampled in IDLE and last FRONT cycle)
//   vsync, href        - registered sync outputs for the current cycle
//   frame_start/done   - registered one-cycle frame pulses
//   busy               - registered, high from frame_start through frame_done
//   byte0_next/byte1_next/frame_start_next
//                      - what the next cycle will be, so the top can register
//                        its byte/address pipeline in step with the sync outputs
import dvp_pkg::*;

module dvp_timing_gen #(
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned H_BLANK     = 144,
    parameter int unsigned VSYNC_LINES = 3,
    parameter int unsigned V_BACK      = 17,
    parameter int unsigned V_FRONT     = 10
) (
    input  logic p_clock,
    input  logic reset,
    input  logic enable,
    output logic vsync,
    output logic href,
    output logic frame_start,
    output logic frame_done,
    output logic busy,
    output logic byte0_next,
    output logic byte1_next,
    output logic frame_start_next
);

    localparam int unsigned LINE_T = 2 * H_ACTIVE + H_BLANK;
    localparam int unsigned VMAX01 = (VSYNC_LINES > V_BACK) ? VSYNC_LINES : V_BACK;
    localparam int unsigned VMAX23 = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
    localparam int unsigned VMAX   = (VMAX01 > VMAX23) ? VMAX01 : VMAX23;
    localparam int unsigned HW     = $clog2(LINE_T + 1);
    localparam int unsigned VW     = $clog2(VMAX + 1);

    dvp_state_e    state_q, state_d;
    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic          href_d, frame_done_d;

    function automatic logic [VW-1:0] last_line(input dvp_state_e s);
        case (s)
            StVsync:  return VW'(VSYNC_LINES - 1);
            StBack:   return VW'(V_BACK - 1);
            StActive: return VW'(V_ACTIVE - 1);
            StFront:  return VW'(V_FRONT - 1);
            default:  return '0;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        v_d     = v_q;
        if (state_q == StIdle) begin
            h_d = '0;
            v_d = '0;
            if (enable) state_d = StVsync;
        end else if (h_q == HW'(LINE_T - 1)) begin
            h_d = '0;
            if (v_q == last_line(state_q)) begin
                v_d = '0;
                case (state_q)
                    StVsync:  state_d = StBack;
                    StBack:   state_d = StActive;
                    StActive: state_d = StFront;
                    default:  state_d = enable ? StVsync : StIdle;
                endcase
            end else begin
                v_d = v_q + VW'(1);
            end
        end else begin
            h_d = h_q + HW'(1);
        end

        // Outputs are decoded from the next position and registered alongside it.
        href_d           = (state_d == StActive) && (h_d < HW'(2 * H_ACTIVE));
        byte0_next       = href_d && !h_d[0];
        byte1_next       = href_d && h_d[0];
        frame_start_next = (state_d == StVsync) && (h_d == '0) && (v_d == '0);
        frame_done_d     = (state_d == StFront) && (h_d == HW'(LINE_T - 1)) &&
                           (v_d == VW'(V_FRONT - 1));
    end

    always_ff @(posedge p_clock) begin
        if (reset) begin
            state_q     <= StIdle;
            h_q         <= '0;
            v_q         <= '0;
            vsync       <= 1'b0;
            href        <= 1'b0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state_q     <= state_d;
            h_q         <= h_d;
            v_q         <= v_d;
            vsync       <= (state_d == StVsync);
            href        <= href_d;
            frame_start <= frame_start_next;
            frame_done  <= frame_done_d;
            busy        <= (state_d != StIdle);
        end
    end

endmodule

// File: rtl/dvp_camera_tx.sv
// dvp_camera_tx: OV7670-style DVP camera source reading RGB444 from a frame buffer.
// Ports:
//   p_clock, reset   - byte clock, synchronous active-high reset
//   enable           - run frames continuously while high
//   mem_addr         - frame-buffer read address (synchronous BRAM, 1-cycle latency)
//   mem_rdata        - {R,G,B} for the previous cycle's mem_addr
//   dvp              - vsync/href/p_data bus (master)
//   frame_start/done - one-cycle frame pulses; busy spans them
//   pattern_sel      - only with DVP_TX_TEST_PATTERN_EN: 8 vertical colour bars
//                      instead of mem_rdata, sampled at frame_start
// Optional feature macro: DVP_TX_TEST_PATTERN_EN
import dvp_pkg::*;

module dvp_camera_tx #(
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned H_BLANK     = 144,
    parameter int unsigned VSYNC_LINES = 3,
    parameter int unsigned V_BACK      = 17,
    parameter int unsigned V_FRONT     = 10,
    parameter int unsigned AW          = 19
) (
    input  logic          p_clock,
    input  logic          reset,
    input  logic          enable,
`ifdef DVP_TX_TEST_PATTERN_EN
    input  logic          pattern_sel,
`endif
    output logic [AW-1:0] mem_addr,
    input  logic [11:0]   mem_rdata,
    dvp_camera_tx_if.master dvp,
    output logic          frame_start,
    output logic          frame_done,
    output logic          busy
);

    localparam int unsigned NPIX = H_ACTIVE * V_ACTIVE;

    logic    vsync_w, href_w;
    logic    byte0_next, byte1_next, frame_start_next;
    rgb444_t pix_q, src_pix;
    logic [7:0] p_data_q;

    dvp_timing_gen #(
        .H_ACTIVE    (H_ACTIVE),
        .V_ACTIVE    (V_ACTIVE),
        .H_BLANK     (H_BLANK),
        .VSYNC_LINES (VSYNC_LINES),
        .V_BACK      (V_BACK),
        .V_FRONT     (V_FRONT)
    ) u_timing (
        .p_clock          (p_clock),
        .reset            (reset),
        .enable           (enable),
        .vsync            (vsync_w),
        .href             (href_w),
        .frame_start      (frame_start),
        .frame_done       (frame_done),
        .busy             (busy),
        .byte0_next       (byte0_next),
        .byte1_next       (byte1_next),
        .frame_start_next (frame_start_next)
    );

    assign dvp.vsync  = vsync_w;
    assign dvp.href   = href_w;
    assign dvp.p_data = p_data_q;

`ifdef DVP_TX_TEST_PATTERN_EN
    localparam int unsigned XW = $clog2(H_ACTIVE + 1);

    logic          pat_q;
    logic [XW-1:0] pix_x_q;
    logic [2:0]    bar_idx;

    always_comb begin
        bar_idx = 3'((int'(pix_x_q) * 8) / int'(H_ACTIVE));
        src_pix = pat_q ? bar_colour(bar_idx) : rgb444_t'(mem_rdata);
    end

    // Column of the pixel about to be emitted; advances on each byte0.
    always_ff @(posedge p_clock) begin
        if (reset) begin
            pat_q   <= 1'b0;
            pix_x_q <= '0;
        end else if (frame_start_next) begin
            pat_q   <= pattern_sel;
            pix_x_q <= '0;
        end else if (byte0_next) begin
            pix_x_q <= (pix_x_q == XW'(H_ACTIVE - 1)) ? '0 : pix_x_q + XW'(1);
        end
    end
`else
    always_comb begin
        src_pix = rgb444_t'(mem_rdata);
    end
`endif

    // On the byte0 edge mem_rdata holds pixel n; latch it for byte1 and
    // step the address so pixel n+1 is ready by the next byte0.
    always_ff @(posedge p_clock) begin
        if (reset) begin
            mem_addr <= '0;
            pix_q    <= '0;
            p_data_q <= '0;
        end else begin
            if (frame_start_next) begin
                mem_addr <= '0;
            end else if (byte0_next) begin
                mem_addr <= (mem_addr == AW'(NPIX - 1)) ? '0 : mem_addr + AW'(1);
            end

            if (byte0_next) begin
                pix_q    <= src_pix;
                p_data_q <= pack_hi(src_pix);
            end else if (byte1_next) begin
                p_data_q <= pack_lo(pix_q);
            end else begin
                p_data_q <= 8'h00;
            end
        end
    end

endmodule
